// File: rtl/glitc_patgen_pkg.sv
// Shared types and constants for the GLITC pattern generator: mode encodings,
// FSM states and the LFSR seed/tap constants used by the optional PRBS source.
package glitc_patgen_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'd0,
    MODE_PLAY = 2'd1,
    MODE_RAMP = 2'd2,
    MODE_PRBS = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, taps on state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/glitc_patgen_if.sv
// Control, RAM-load and sample-word bus of the GLITC pattern generator.
// master drives configuration/commands; slave is the generator itself.
interface glitc_patgen_if #(
  parameter int NCH   = 6,
  parameter int NBITS = 3,
  parameter int NSAMP = 4,
  parameter int AW    = 6
);
  logic                        wr_en;
  logic [2:0]                  wr_ch;
  logic [AW-1:0]               wr_addr;
  logic [NBITS-1:0]            wr_data;
  logic [1:0]                  mode;
  logic                        oneshot;
  logic [NBITS-1:0]            inv_mask;
  logic                        start;
  logic                        stop;
  logic                        busy;
  logic                        done;
  logic [NCH*NSAMP*NBITS-1:0]  dout;
  logic                        dout_valid;
  logic                        ref_out;

  modport master (
    output wr_en, wr_ch, wr_addr, wr_data, mode, oneshot, inv_mask, start, stop,
    input  busy, done, dout, dout_valid, ref_out
  );

  modport slave (
    input  wr_en, wr_ch, wr_addr, wr_data, mode, oneshot, inv_mask, start, stop,
    output busy, done, dout, dout_valid, ref_out
  );
endinterface

// File: rtl/glitc_patgen_chan.sv
// One generator channel: playback RAM, ramp source and, when
// GLITC_PATGEN_PRBS_EN is defined, a per-channel LFSR. Word output is combinational.
module glitc_patgen_chan
  import glitc_patgen_pkg::*;
#(
  parameter int CH    = 0,
  parameter int NBITS = 3,
  parameter int NSAMP = 4,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                     clk,
`ifdef GLITC_PATGEN_PRBS_EN
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     step,
`endif
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [NBITS-1:0]         wr_data,
  input  mode_e                    mode,
  input  logic [AW-1:0]            ptr,
  output logic [NSAMP*NBITS-1:0]   word
);

  logic [NBITS-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
  end

`ifdef GLITC_PATGEN_PRBS_EN
  if (NSAMP * NBITS > 16) begin : g_prbs_too_wide
    $error("glitc_patgen_chan: NSAMP*NBITS exceeds the 16-bit LFSR");
  end

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_cur;

  // The word emitted on the start cycle is taken straight from the seed.
  assign lfsr_cur = load ? (LFSR_SEED ^ 16'(CH)) : lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else if (step) lfsr_q <= {lfsr_cur[14:0], ^(lfsr_cur & LFSR_TAPS)};
  end
`endif

  always_comb begin
    word = '0;
    for (int i = 0; i < NSAMP; i++) begin
      case (mode)
        MODE_PLAY: word[i*NBITS +: NBITS] = ram[ptr + AW'(i)];
        MODE_RAMP: word[i*NBITS +: NBITS] = NBITS'(int'(ptr) + i + CH);
`ifdef GLITC_PATGEN_PRBS_EN
        MODE_PRBS: word[i*NBITS +: NBITS] = lfsr_cur[i*NBITS +: NBITS];
`endif
        default:   word[i*NBITS +: NBITS] = '0;
      endcase
    end
  end

endmodule

// File: rtl/glitc_pattern_gen.sv
// GLITC multi-channel sample-word source: run FSM, sample pointer, strobe and
// output inversion. Define GLITC_PATGEN_PRBS_EN to enable the mode-3 PRBS source.
//
//   state   | meaning
//   ST_IDLE | no words generated; dout=0, waiting for start
//   ST_RUN  | one word per clk from ptr; leaves on stop or one-shot end
module glitc_pattern_gen
  import glitc_patgen_pkg::*;
#(
  parameter int NCH   = 6,
  parameter int NBITS = 3,
  parameter int NSAMP = 4,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  glitc_patgen_if.slave   bus
);

  localparam int WW = NSAMP * NBITS;

  if ((1 << AW) != DEPTH || (DEPTH % NSAMP) != 0) begin : g_bad_depth
    $error("glitc_pattern_gen: DEPTH must be 2**AW and a multiple of NSAMP");
  end

  state_e            state_q, state_d;
  logic [AW-1:0]     ptr_q, cur_ptr;
  mode_e             mode_q, cur_mode;
  logic              oneshot_q, cur_oneshot;
  logic              go, gen, last;
  logic [NCH*WW-1:0] word;
  logic [NCH*WW-1:0] inv_word;

  // On the start cycle the live mode/oneshot and ptr 0 drive the first word.
  always_comb begin
    go          = (state_q == ST_IDLE) && bus.start && !bus.stop;
    gen         = go || ((state_q == ST_RUN) && !bus.stop);
    cur_ptr     = go ? '0 : ptr_q;
    cur_mode    = go ? mode_e'(bus.mode) : mode_q;
    cur_oneshot = go ? bus.oneshot : oneshot_q;
    last        = gen && cur_oneshot && (cur_ptr == AW'(DEPTH - NSAMP));
    state_d     = (gen && !last) ? ST_RUN : ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign inv_word = {(NCH*NSAMP){bus.inv_mask}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q          <= '0;
      mode_q         <= MODE_ZERO;
      oneshot_q      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.ref_out    <= 1'b0;
    end else begin
      if (go) begin
        mode_q    <= cur_mode;
        oneshot_q <= cur_oneshot;
      end
      // Pointer wraps naturally at DEPTH since DEPTH is 2**AW.
      ptr_q          <= gen ? cur_ptr + AW'(NSAMP) : '0;
      bus.busy       <= gen;
      bus.done       <= last;
      bus.dout_valid <= gen;
      bus.dout       <= gen ? (word ^ inv_word) : '0;
      if (gen) bus.ref_out <= ~bus.ref_out;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    glitc_patgen_chan #(
      .CH    (c),
      .NBITS (NBITS),
      .NSAMP (NSAMP),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_chan (
      .clk     (clk),
`ifdef GLITC_PATGEN_PRBS_EN
      .rst_n   (rst_n),
      .load    (go),
      .step    (gen),
`endif
      .wr_en   (bus.wr_en && (bus.wr_ch == 3'(c))),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .mode    (cur_mode),
      .ptr     (cur_ptr),
      .word    (word[c*WW +: WW])
    );
  end

endmodule

// File: tb/tb_glitc_pattern_gen.sv
// Self-checking bench for glitc_pattern_gen: scoreboard of expected words built
// from a reference model of RAM contents, ramp and LFSR.
module tb_glitc_pattern_gen;
  import glitc_patgen_pkg::*;

  localparam int NCH = 6, NBITS = 3, NSAMP = 4, DEPTH = 64, AW = 6;
  localparam int W  = NCH * NSAMP * NBITS;
  localparam int NW = DEPTH / NSAMP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [NBITS-1:0] mram [NCH][DEPTH];
  logic [15:0]      lfsr_m [NCH];
  logic [W-1:0]     sb [$];

  glitc_patgen_if #(.NCH(NCH), .NBITS(NBITS), .NSAMP(NSAMP), .AW(AW)) bus ();

  glitc_pattern_gen #(.NCH(NCH), .NBITS(NBITS), .NSAMP(NSAMP), .DEPTH(DEPTH), .AW(AW))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NBITS-1:0] samp(logic [W-1:0] w, int c, int i);
    return w[(c*NSAMP+i)*NBITS +: NBITS];
  endfunction

  function automatic logic [W-1:0] exp_word(int md, int p, logic [NBITS-1:0] inv);
    logic [W-1:0]     w;
    logic [NBITS-1:0] s;
    w = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < NSAMP; i++) begin
        case (md)
          1: s = mram[c][(p+i) % DEPTH];
          2: s = NBITS'((p + i + c) % 8);
`ifdef GLITC_PATGEN_PRBS_EN
          3: s = lfsr_m[c][i*NBITS +: NBITS];
`endif
          default: s = '0;
        endcase
        w[(c*NSAMP+i)*NBITS +: NBITS] = s ^ inv;
      end
    end
    return w;
  endfunction

  task automatic test_reset();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.dout_valid); end
    checks++; if (bus.ref_out !== 1'b0) begin errors++; $display("FAIL reset_ref got %b want 0", bus.ref_out); end
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", bus.dout); end
  endtask

  task automatic load_ram();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < DEPTH; k++) begin
        bus.wr_en = 1'b1; bus.wr_ch = 3'(c); bus.wr_addr = AW'(k);
        bus.wr_data = NBITS'((k + c) & 7);
        mram[c][k] = NBITS'((k + c) & 7);
        tick();
      end
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_playback_oneshot();
    logic [W-1:0] exp;
    logic [11:0]  ch0;
    bus.mode = 2'd1; bus.oneshot = 1'b1; bus.inv_mask = '0;
    for (int k = 0; k < NW; k++) sb.push_back(exp_word(1, k*NSAMP, '0));
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int k = 0; k < NW; k++) begin
      checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL play_valid word %0d got %b want 1", k, bus.dout_valid); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL play_busy word %0d got %b want 1", k, bus.busy); end
      checks++; if (bus.done !== (k == NW-1)) begin errors++; $display("FAIL play_done word %0d got %b want %b", k, bus.done, (k == NW-1)); end
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL play_sb word %0d got output want none", k); end
      else begin
        exp = sb.pop_front();
        if (bus.dout !== exp) begin errors++; $display("FAIL play_word %0d got %h want %h", k, bus.dout, exp); end
      end
      if (k == 0) begin
        ch0 = bus.dout[11:0];
        checks++; if (ch0 !== {3'd3, 3'd2, 3'd1, 3'd0}) begin errors++; $display("FAIL play_ch0_w0 got %h want %h", ch0, {3'd3, 3'd2, 3'd1, 3'd0}); end
      end
      tick();
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL play_busy_end got %b want 0", bus.busy); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL play_valid_end got %b want 0", bus.dout_valid); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL play_done_end got %b want 0", bus.done); end
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL play_dout_end got %h want 0", bus.dout); end
  endtask

  task automatic test_ramp_loop();
    logic [W-1:0] exp, w0;
    logic         prev_ref;
    w0 = '0; prev_ref = 1'b0;
    bus.mode = 2'd2; bus.oneshot = 1'b0; bus.inv_mask = '0;
    for (int k = 0; k < 20; k++) sb.push_back(exp_word(2, (k*NSAMP) % DEPTH, '0));
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL ramp_valid word %0d got %b want 1", k, bus.dout_valid); end
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL ramp_sb word %0d got output want none", k); end
      else begin
        exp = sb.pop_front();
        if (bus.dout !== exp) begin errors++; $display("FAIL ramp_word %0d got %h want %h", k, bus.dout, exp); end
      end
      if (k == 0) w0 = bus.dout;
      if (k == 16) begin
        checks++; if (bus.dout !== w0) begin errors++; $display("FAIL ramp_wrap got %h want %h", bus.dout, w0); end
      end
      if (k > 0) begin
        checks++; if (bus.ref_out !== ~prev_ref) begin errors++; $display("FAIL ramp_ref word %0d got %b want %b", k, bus.ref_out, ~prev_ref); end
      end
      prev_ref = bus.ref_out;
      // mode/oneshot changes during the run must be ignored
      if (k == 2) begin bus.mode = 2'd0; bus.oneshot = 1'b1; end
      if (k == 19) bus.stop = 1'b1;
      tick();
    end
    bus.stop = 1'b0;
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL ramp_stop_valid got %b want 0", bus.dout_valid); end
  endtask

  task automatic test_inversion();
    logic [W-1:0] exp;
    logic [11:0]  ch0;
    bus.mode = 2'd2; bus.oneshot = 1'b0; bus.inv_mask = 3'b100;
    sb.push_back(exp_word(2, 0, bus.inv_mask));
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL inv_sb word %0d got output want none", k); end
      else begin
        exp = sb.pop_front();
        if (bus.dout !== exp) begin errors++; $display("FAIL inv_word %0d got %h want %h", k, bus.dout, exp); end
      end
      if (k == 0) begin
        ch0 = bus.dout[11:0];
        checks++; if (ch0 !== {3'd7, 3'd6, 3'd5, 3'd4}) begin errors++; $display("FAIL inv_ch0_w0 got %h want %h", ch0, {3'd7, 3'd6, 3'd5, 3'd4}); end
      end
      if (k == 2) bus.inv_mask = 3'b000;
      if (k < 5) sb.push_back(exp_word(2, (k+1)*NSAMP, bus.inv_mask));
      else bus.stop = 1'b1;
      tick();
    end
    bus.stop = 1'b0;
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL inv_idle_dout got %h want 0", bus.dout); end
  endtask

  task automatic test_start_stop();
    logic [W-1:0] exp;
    logic         ref_hold;
    bus.mode = 2'd2; bus.oneshot = 1'b0; bus.inv_mask = '0;
    bus.start = 1'b1; bus.stop = 1'b1; tick(); bus.start = 1'b0; bus.stop = 1'b0;
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL ss_same_valid got %b want 0", bus.dout_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ss_same_busy got %b want 0", bus.busy); end
    tick();
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL ss_same_valid2 got %b want 0", bus.dout_valid); end
    for (int k = 0; k < 6; k++) sb.push_back(exp_word(2, k*NSAMP, '0));
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    ref_hold = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL ss_sb word %0d got output want none", k); end
      else begin
        exp = sb.pop_front();
        if (bus.dout !== exp) begin errors++; $display("FAIL ss_word %0d got %h want %h", k, bus.dout, exp); end
      end
      if (k == 5) begin ref_hold = bus.ref_out; bus.stop = 1'b1; end
      tick();
    end
    bus.stop = 1'b0;
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL ss_stop_valid got %b want 0", bus.dout_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ss_stop_busy got %b want 0", bus.busy); end
    checks++; if (bus.ref_out !== ref_hold) begin errors++; $display("FAIL ss_ref_hold got %b want %b", bus.ref_out, ref_hold); end
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL ss_stop_dout got %h want 0", bus.dout); end
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] exp;
    bus.mode = 2'd2; bus.oneshot = 1'b0; bus.inv_mask = '0;
    for (int k = 0; k < 4; k++) sb.push_back(exp_word(2, k*NSAMP, '0));
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL rst_sb word %0d got output want none", k); end
      else begin
        exp = sb.pop_front();
        if (bus.dout !== exp) begin errors++; $display("FAIL rst_word %0d got %h want %h", k, bus.dout, exp); end
      end
      if (k == 3) rst_n = 1'b0;
      tick();
    end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", bus.dout_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    checks++; if (bus.ref_out !== 1'b0) begin errors++; $display("FAIL rst_mid_ref got %b want 0", bus.ref_out); end
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL rst_mid_dout got %h want 0", bus.dout); end
    rst_n = 1'b1; tick();
    exp = exp_word(2, 0, '0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    checks++; if (bus.dout !== exp) begin errors++; $display("FAIL rst_restart_word got %h want %h", bus.dout, exp); end
    checks++; if (bus.ref_out !== 1'b1) begin errors++; $display("FAIL rst_restart_ref got %b want 1", bus.ref_out); end
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
  endtask

  task automatic test_write_during_play();
    logic [W-1:0]     exp;
    logic [NBITS-1:0] s;
    bus.mode = 2'd1; bus.oneshot = 1'b0; bus.inv_mask = '0;
    sb.push_back(exp_word(1, 0, '0));
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL wr_sb word %0d got output want none", k); end
      else begin
        exp = sb.pop_front();
        if (bus.dout !== exp) begin errors++; $display("FAIL wr_word %0d got %h want %h", k, bus.dout, exp); end
      end
      if (k == 2) begin
        s = samp(bus.dout, 2, 0);
        checks++; if (s !== 3'd2) begin errors++; $display("FAIL wr_same_pass got %0d want 2", s); end
      end
      if (k == 18) begin
        s = samp(bus.dout, 2, 0);
        checks++; if (s !== 3'd7) begin errors++; $display("FAIL wr_next_pass got %0d want 7", s); end
      end
      bus.wr_en = 1'b0;
      if (k == 1) begin
        bus.wr_en = 1'b1; bus.wr_ch = 3'd2; bus.wr_addr = AW'(8); bus.wr_data = 3'd7;
      end else if (k == 2) begin
        bus.wr_en = 1'b1; bus.wr_ch = 3'd6; bus.wr_addr = AW'(8); bus.wr_data = 3'd0;
      end
      if (k < 19) sb.push_back(exp_word(1, ((k+1)*NSAMP) % DEPTH, '0));
      else bus.stop = 1'b1;
      if (k == 1) mram[2][8] = 3'd7;
      tick();
    end
    bus.wr_en = 1'b0; bus.stop = 1'b0;
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL wr_stop_valid got %b want 0", bus.dout_valid); end
  endtask

  task automatic test_prbs();
    logic [W-1:0] exp;
    logic [11:0]  ch0;
    bus.mode = 2'd3; bus.oneshot = 1'b1; bus.inv_mask = '0;
    for (int c = 0; c < NCH; c++) lfsr_m[c] = 16'hACE1 ^ 16'(c);
    for (int k = 0; k < NW; k++) begin
      sb.push_back(exp_word(3, k*NSAMP, '0));
      for (int c = 0; c < NCH; c++)
        lfsr_m[c] = {lfsr_m[c][14:0], lfsr_m[c][15] ^ lfsr_m[c][13] ^ lfsr_m[c][12] ^ lfsr_m[c][10]};
    end
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int k = 0; k < NW; k++) begin
      checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL prbs_valid word %0d got %b want 1", k, bus.dout_valid); end
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL prbs_sb word %0d got output want none", k); end
      else begin
        exp = sb.pop_front();
        if (bus.dout !== exp) begin errors++; $display("FAIL prbs_word %0d got %h want %h", k, bus.dout, exp); end
      end
      if (k == 0) begin
        ch0 = bus.dout[11:0];
`ifdef GLITC_PATGEN_PRBS_EN
        checks++; if (ch0 !== 12'hCE1) begin errors++; $display("FAIL prbs_ch0_w0 got %h want ce1", ch0); end
`else
        checks++; if (ch0 !== 12'h000) begin errors++; $display("FAIL prbs_ch0_w0 got %h want 000", ch0); end
`endif
      end
      checks++; if (bus.done !== (k == NW-1)) begin errors++; $display("FAIL prbs_done word %0d got %b want %b", k, bus.done, (k == NW-1)); end
      tick();
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL prbs_busy_end got %b want 0", bus.busy); end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.mode = '0; bus.oneshot = 1'b0; bus.inv_mask = '0;
    bus.start = 1'b0; bus.stop = 1'b0;
    rst_n = 1'b0;
    tick(); tick(); tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    load_ram();
    test_playback_oneshot();
    test_ramp_loop();
    test_inversion();
    test_start_stop();
    test_reset_midrun();
    test_write_during_play();
    test_prbs();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
